mc_ctrl_fsm: RTL and testbench

- Multi-cycle MIPS control unit that drives the ALU opcode and all datapath select and enable lines. It is the issuing end of the ALU/datapath interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Handshakes with instruction and data memories that have variable latency.
- Flags a stuck memory with a wait-cycle timeout.

---
 rtl/mc_ctrl_pkg.sv | 80 ++++++++
 rtl/mc_ctrl_fsm_if.sv | 39 +++
 rtl/mc_ctrl_decode.sv | 64 ++++++
 rtl/mc_ctrl_fsm.sv | 188 ++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS controller: ALU encodings, opcodes,
// funct codes, FSM state encodings, datapath mux selects and the instruction class.
package mc_ctrl_pkg;

  // ALU operation encoding, must match the ALU.
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_LUI  = 3'b011;
  localparam logic [2:0] ALU_SLL  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [2:0] ST_IF   = 3'd0;
  localparam logic [2:0] ST_ID   = 3'd1;
  localparam logic [2:0] ST_EX   = 3'd2;
  localparam logic [2:0] ST_MEM  = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;
  localparam logic [2:0] ST_HALT = 3'd5;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS    = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  localparam logic [2:0] SRCB_RT       = 3'd0;
  localparam logic [2:0] SRCB_FOUR     = 3'd1;
  localparam logic [2:0] SRCB_SIMM     = 3'd2;
  localparam logic [2:0] SRCB_SIMM_SH2 = 3'd3;
  localparam logic [2:0] SRCB_ZIMM     = 3'd4;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  typedef enum logic [3:0] {
    CLS_RALU,
    CLS_IALU,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_JAL,
    CLS_JR,
    CLS_ILL
  } inst_class_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath/memory bundle. master = controller (issuing end),
// slave = datapath and memories. Acks are same-cycle: a request is accepted on
// any cycle where req and its ack are both high, with no ready/valid pipelining.
interface mc_ctrl_fsm_if;
  import mc_ctrl_pkg::*;

  logic [5:0] ir_op;
  logic [5:0] ir_funct;
  logic       alu_zero;
  logic       inst_ack;
  logic       data_ack;
  logic       inst_req;
  logic       data_req;
  logic       data_wr;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_src;
  logic [2:0] alu_op;
  logic [1:0] alu_src_a;
  logic [2:0] alu_src_b;
  logic       reg_we;
  logic [1:0] reg_dst;
  logic [1:0] wb_src;
  logic       illegal_inst;
  logic       mem_err;

  modport master (
    input  ir_op, ir_funct, alu_zero, inst_ack, data_ack,
    output inst_req, data_req, data_wr, ir_we, pc_we, pc_src, alu_op,
           alu_src_a, alu_src_b, reg_we, reg_dst, wb_src, illegal_inst, mem_err
  );

  modport slave (
    output ir_op, ir_funct, alu_zero, inst_ack, data_ack,
    input  inst_req, data_req, data_wr, ir_we, pc_we, pc_src, alu_op,
           alu_src_a, alu_src_b, reg_we, reg_dst, wb_src, illegal_inst, mem_err
  );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Purely combinational instruction decoder: op/funct to instruction class plus
// the execute-stage ALU op and operand selects.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output inst_class_t cls,
  output logic [2:0]  alu_op,
  output logic [1:0]  alu_src_a,
  output logic [2:0]  alu_src_b,
  output logic        illegal
);

  always_comb begin
    cls       = CLS_ILL;
    alu_op    = ALU_AND;
    alu_src_a = SRCA_PC;
    alu_src_b = SRCB_RT;
    case (op)
      OP_RTYPE: begin
        cls       = CLS_RALU;
        alu_src_a = SRCA_RS;
        alu_src_b = SRCB_RT;
        case (funct)
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_SLL: begin
            alu_op    = ALU_SLL;
            alu_src_a = SRCA_SHAMT;
          end
          FN_JR: begin
            // jr only redirects the PC; the ALU is left idle.
            cls       = CLS_JR;
            alu_src_a = SRCA_PC;
          end
          default: begin
            cls       = CLS_ILL;
            alu_src_a = SRCA_PC;
          end
        endcase
      end
      OP_ADDIU: begin cls = CLS_IALU; alu_op = ALU_ADD;  alu_src_a = SRCA_RS; alu_src_b = SRCB_SIMM; end
      OP_SLTIU: begin cls = CLS_IALU; alu_op = ALU_SLTU; alu_src_a = SRCA_RS; alu_src_b = SRCB_SIMM; end
      OP_ANDI:  begin cls = CLS_IALU; alu_op = ALU_AND;  alu_src_a = SRCA_RS; alu_src_b = SRCB_ZIMM; end
      OP_ORI:   begin cls = CLS_IALU; alu_op = ALU_OR;   alu_src_a = SRCA_RS; alu_src_b = SRCB_ZIMM; end
      OP_LUI:   begin cls = CLS_IALU; alu_op = ALU_LUI;  alu_src_a = SRCA_RS; alu_src_b = SRCB_ZIMM; end
      OP_LW:    begin cls = CLS_LW;   alu_op = ALU_ADD;  alu_src_a = SRCA_RS; alu_src_b = SRCB_SIMM; end
      OP_SW:    begin cls = CLS_SW;   alu_op = ALU_ADD;  alu_src_a = SRCA_RS; alu_src_b = SRCB_SIMM; end
      OP_BEQ:   begin cls = CLS_BEQ;  alu_op = ALU_SUB;  alu_src_a = SRCA_RS; alu_src_b = SRCB_RT;   end
      OP_BNE:   begin cls = CLS_BNE;  alu_op = ALU_SUB;  alu_src_a = SRCA_RS; alu_src_b = SRCB_RT;   end
      OP_J:     cls = CLS_J;
      OP_JAL:   cls = CLS_JAL;
      default:  cls = CLS_ILL;
    endcase
  end

  assign illegal = (cls == CLS_ILL);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB/HALT) with variable-latency
// memory handshakes and a sticky wait-cycle timeout that parks the FSM in HALT.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                clk,
  input  logic                rst,
  mc_ctrl_fsm_if.master       bus,
  output logic [2:0]          state_dbg
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_err_q;
  logic             timeout;
  logic             waiting;

  inst_class_t cls;
  logic [2:0]  dec_alu_op;
  logic [1:0]  dec_src_a;
  logic [2:0]  dec_src_b;
  logic        dec_illegal;

  logic       inst_req_c, data_req_c, data_wr_c, ir_we_c, pc_we_c, reg_we_c, illegal_c;
  logic [1:0] pc_src_c, alu_src_a_c, reg_dst_c, wb_src_c;
  logic [2:0] alu_op_c, alu_src_b_c;

  mc_ctrl_decode u_decode (
    .op        (bus.ir_op),
    .funct     (bus.ir_funct),
    .cls       (cls),
    .alu_op    (dec_alu_op),
    .alu_src_a (dec_src_a),
    .alu_src_b (dec_src_b),
    .illegal   (dec_illegal)
  );

  always_comb begin
    state_nxt   = state;
    timeout     = 1'b0;
    inst_req_c  = 1'b0;
    data_req_c  = 1'b0;
    data_wr_c   = 1'b0;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    reg_we_c    = 1'b0;
    illegal_c   = 1'b0;
    pc_src_c    = PC_SRC_ALU;
    alu_src_a_c = SRCA_PC;
    alu_src_b_c = SRCB_RT;
    alu_op_c    = ALU_AND;
    reg_dst_c   = DST_RT;
    wb_src_c    = WB_ALU;
    case (state)
      ST_IF: begin
        inst_req_c  = 1'b1;
        alu_src_a_c = SRCA_PC;
        alu_src_b_c = SRCB_FOUR;
        alu_op_c    = ALU_ADD;
        // An ack in the final allowed cycle still wins over the timeout.
        if (bus.inst_ack) begin
          ir_we_c   = 1'b1;
          pc_we_c   = 1'b1;
          pc_src_c  = PC_SRC_ALU;
          state_nxt = ST_ID;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          timeout   = 1'b1;
          state_nxt = ST_HALT;
        end
      end
      ST_ID: begin
        alu_src_a_c = SRCA_PC;
        alu_src_b_c = SRCB_SIMM_SH2;
        alu_op_c    = ALU_ADD;
        case (cls)
          CLS_J: begin
            pc_we_c   = 1'b1;
            pc_src_c  = PC_SRC_JUMP;
            state_nxt = ST_IF;
          end
          CLS_JAL: begin
            pc_we_c   = 1'b1;
            pc_src_c  = PC_SRC_JUMP;
            reg_we_c  = 1'b1;
            reg_dst_c = DST_RA;
            wb_src_c  = WB_PC;
            state_nxt = ST_IF;
          end
          default: begin
            if (dec_illegal) begin
              illegal_c = 1'b1;
              state_nxt = ST_IF;
            end else begin
              state_nxt = ST_EX;
            end
          end
        endcase
      end
      ST_EX: begin
        alu_op_c    = dec_alu_op;
        alu_src_a_c = dec_src_a;
        alu_src_b_c = dec_src_b;
        case (cls)
          CLS_RALU, CLS_IALU: state_nxt = ST_WB;
          CLS_LW, CLS_SW:     state_nxt = ST_MEM;
          CLS_BEQ: begin
            pc_src_c  = PC_SRC_ALUOUT;
            pc_we_c   = bus.alu_zero;
            state_nxt = ST_IF;
          end
          CLS_BNE: begin
            pc_src_c  = PC_SRC_ALUOUT;
            pc_we_c   = ~bus.alu_zero;
            state_nxt = ST_IF;
          end
          CLS_JR: begin
            pc_we_c   = 1'b1;
            pc_src_c  = PC_SRC_RS;
            state_nxt = ST_IF;
          end
          default: state_nxt = ST_IF;
        endcase
      end
      ST_MEM: begin
        data_req_c = 1'b1;
        data_wr_c  = (cls == CLS_SW);
        if (bus.data_ack) begin
          state_nxt = (cls == CLS_LW) ? ST_WB : ST_IF;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          timeout   = 1'b1;
          state_nxt = ST_HALT;
        end
      end
      ST_WB: begin
        reg_we_c  = 1'b1;
        reg_dst_c = (bus.ir_op == OP_RTYPE) ? DST_RD : DST_RT;
        wb_src_c  = (cls == CLS_LW) ? WB_MEM : WB_ALU;
        state_nxt = ST_IF;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IF;
    endcase
  end

  assign waiting = (state == ST_IF) || (state == ST_MEM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IF;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (timeout) begin
        mem_err_q <= 1'b1;
      end
      // Any ack moves the FSM on, so a state change also covers ack clearing.
      if (waiting && (state_nxt == state)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign bus.inst_req     = inst_req_c & ~rst;
  assign bus.data_req     = data_req_c & ~rst;
  assign bus.data_wr      = data_wr_c & ~rst;
  assign bus.ir_we        = ir_we_c & ~rst;
  assign bus.pc_we        = pc_we_c & ~rst;
  assign bus.reg_we       = reg_we_c & ~rst;
  assign bus.illegal_inst = illegal_c & ~rst;
  assign bus.pc_src       = rst ? 2'd0 : pc_src_c;
  assign bus.alu_op       = rst ? 3'd0 : alu_op_c;
  assign bus.alu_src_a    = rst ? 2'd0 : alu_src_a_c;
  assign bus.alu_src_b    = rst ? 3'd0 : alu_src_b_c;
  assign bus.reg_dst      = rst ? 2'd0 : reg_dst_c;
  assign bus.wb_src       = rst ? 2'd0 : wb_src_c;
  assign bus.mem_err      = mem_err_q & ~rst;
  assign state_dbg        = rst ? 3'd0 : state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction expected cycle traces built from the
// instruction rules, plus a second instance with a short timeout.
module tb_mc_ctrl_fsm;

  localparam int OW = 25;
  localparam logic [2:0] A_AND = 3'd0, A_OR = 3'd1, A_ADD = 3'd2, A_LUI = 3'd3;
  localparam logic [2:0] A_SLL = 3'd4, A_SLTU = 3'd5, A_SUB = 3'd6, A_SLT = 3'd7;
  localparam int K_RALU = 0, K_IALU = 1, K_LW = 2, K_SW = 3, K_BEQ = 4;
  localparam int K_BNE = 5, K_J = 6, K_JAL = 7, K_JR = 8, K_ILL = 9;

  typedef struct packed {
    logic [2:0] st;
    logic       inst_req;
    logic       data_req;
    logic       data_wr;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic [1:0] src_a;
    logic [2:0] src_b;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic       ill;
    logic       mem_err;
  } obs_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       inst_ack;
    logic       data_ack;
    logic       zero;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_ctrl_fsm_if bus ();
  mc_ctrl_fsm_if bus2 ();
  logic [2:0] dbg, dbg2;

  mc_ctrl_fsm dut (.clk(clk), .rst(rst), .bus(bus), .state_dbg(dbg));
  mc_ctrl_fsm #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut_to (.clk(clk), .rst(rst), .bus(bus2), .state_dbg(dbg2));

  logic [OW-1:0] exp_q[$];
  stim_t         stim_q[$];
  int            checks = 0;
  int            errors = 0;

  // ---------------- reference model ----------------
  function automatic void classify(input logic [5:0] op, input logic [5:0] fn, output int k,
                                   output logic [2:0] aop, output logic [1:0] sa, output logic [2:0] sb);
    k = K_ILL; aop = 3'd0; sa = 2'd0; sb = 3'd0;
    if (op == 6'h00) begin
      k = K_RALU; sa = 2'd1; sb = 3'd0;
      case (fn)
        6'h21: aop = A_ADD;
        6'h23: aop = A_SUB;
        6'h24: aop = A_AND;
        6'h25: aop = A_OR;
        6'h2A: aop = A_SLT;
        6'h2B: aop = A_SLTU;
        6'h00: begin aop = A_SLL; sa = 2'd2; end
        6'h08: begin k = K_JR; sa = 2'd0; end
        default: begin k = K_ILL; sa = 2'd0; end
      endcase
    end else begin
      case (op)
        6'h09: begin k = K_IALU; aop = A_ADD;  sa = 2'd1; sb = 3'd2; end
        6'h0B: begin k = K_IALU; aop = A_SLTU; sa = 2'd1; sb = 3'd2; end
        6'h0C: begin k = K_IALU; aop = A_AND;  sa = 2'd1; sb = 3'd4; end
        6'h0D: begin k = K_IALU; aop = A_OR;   sa = 2'd1; sb = 3'd4; end
        6'h0F: begin k = K_IALU; aop = A_LUI;  sa = 2'd1; sb = 3'd4; end
        6'h23: begin k = K_LW;   aop = A_ADD;  sa = 2'd1; sb = 3'd2; end
        6'h2B: begin k = K_SW;   aop = A_ADD;  sa = 2'd1; sb = 3'd2; end
        6'h04: begin k = K_BEQ;  aop = A_SUB;  sa = 2'd1; sb = 3'd0; end
        6'h05: begin k = K_BNE;  aop = A_SUB;  sa = 2'd1; sb = 3'd0; end
        6'h02: k = K_J;
        6'h03: k = K_JAL;
        default: k = K_ILL;
      endcase
    end
  endfunction

  task automatic push(input stim_t s, input obs_t e);
    stim_q.push_back(s);
    exp_q.push_back(OW'(e));
  endtask

  // Appends the expected cycle-by-cycle trace of one instruction.
  // zsel: 0/1 forces alu_zero during EX, 2 randomizes it.
  task automatic push_inst(input logic [5:0] op, input logic [5:0] fn, input int idly,
                           input int ddly, input int zsel);
    obs_t e; stim_t s; int k; logic [2:0] aop; logic [1:0] sa; logic [2:0] sb;
    classify(op, fn, k, aop, sa, sb);
    for (int i = 0; i <= idly; i++) begin
      e = '0; e.st = 3'd0; e.inst_req = 1'b1; e.src_b = 3'd1; e.alu_op = A_ADD;
      s.op = 6'($urandom); s.fn = 6'($urandom); s.zero = 1'($urandom);
      s.inst_ack = (i == idly); s.data_ack = 1'($urandom);
      if (i == idly) begin e.ir_we = 1'b1; e.pc_we = 1'b1; end
      push(s, e);
    end
    e = '0; e.st = 3'd1; e.src_b = 3'd3; e.alu_op = A_ADD;
    s.op = op; s.fn = fn; s.inst_ack = 1'($urandom); s.data_ack = 1'($urandom); s.zero = 1'($urandom);
    if (k == K_J || k == K_JAL) begin e.pc_we = 1'b1; e.pc_src = 2'd2; end
    if (k == K_JAL) begin e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wb_src = 2'd2; end
    if (k == K_ILL) e.ill = 1'b1;
    push(s, e);
    if (k == K_J || k == K_JAL || k == K_ILL) return;
    e = '0; e.st = 3'd2; e.alu_op = aop; e.src_a = sa; e.src_b = sb;
    s.inst_ack = 1'($urandom); s.data_ack = 1'($urandom);
    s.zero = (zsel == 2) ? 1'($urandom) : 1'(zsel);
    if (k == K_BEQ || k == K_BNE) begin
      e.pc_src = 2'd1;
      e.pc_we = (k == K_BEQ) ? s.zero : ~s.zero;
    end
    if (k == K_JR) begin e.pc_we = 1'b1; e.pc_src = 2'd3; end
    push(s, e);
    if (k == K_BEQ || k == K_BNE || k == K_JR) return;
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= ddly; i++) begin
        e = '0; e.st = 3'd3; e.data_req = 1'b1; e.data_wr = (k == K_SW);
        s.inst_ack = 1'($urandom); s.data_ack = (i == ddly); s.zero = 1'($urandom);
        push(s, e);
      end
      if (k == K_SW) return;
    end
    e = '0; e.st = 3'd4; e.reg_we = 1'b1;
    e.reg_dst = (op == 6'h00) ? 2'd1 : 2'd0;
    e.wb_src = (k == K_LW) ? 2'd1 : 2'd0;
    s.inst_ack = 1'($urandom); s.data_ack = 1'($urandom); s.zero = 1'($urandom);
    push(s, e);
  endtask

  // ---------------- driver / scoreboard ----------------
  task automatic drive_idle();
    bus.ir_op = 6'h00; bus.ir_funct = 6'h00; bus.alu_zero = 1'b0;
    bus.inst_ack = 1'b0; bus.data_ack = 1'b0;
    bus2.ir_op = 6'h02; bus2.ir_funct = 6'h00; bus2.alu_zero = 1'b0;
    bus2.inst_ack = 1'b0; bus2.data_ack = 1'b0;
  endtask

  function automatic obs_t sample_main();
    obs_t o;
    o.st = dbg; o.inst_req = bus.inst_req; o.data_req = bus.data_req; o.data_wr = bus.data_wr;
    o.ir_we = bus.ir_we; o.pc_we = bus.pc_we; o.pc_src = bus.pc_src; o.alu_op = bus.alu_op;
    o.src_a = bus.alu_src_a; o.src_b = bus.alu_src_b; o.reg_we = bus.reg_we;
    o.reg_dst = bus.reg_dst; o.wb_src = bus.wb_src; o.ill = bus.illegal_inst; o.mem_err = bus.mem_err;
    return o;
  endfunction

  task automatic run_trace(input string name, input int max_cycles);
    stim_t s; logic [OW-1:0] e; obs_t a; int n;
    n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      bus.ir_op = s.op; bus.ir_funct = s.fn; bus.alu_zero = s.zero;
      bus.inst_ack = s.inst_ack; bus.data_ack = s.data_ack;
      @(negedge clk);
      a = sample_main();
      checks++;
      if (OW'(a) !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h (op %h fn %h)", name, n, OW'(a), e, s.op, s.fn);
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; drive_idle();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic step_to(input logic [2:0] st, input string name);
    @(negedge clk);
    checks++;
    if (dbg2 !== st || bus2.inst_req !== (st == 3'd0) || bus2.data_req !== (st == 3'd3) ||
        bus2.mem_err !== (st == 3'd5)) begin
      errors++;
      $display("FAIL %s: state %0d inst_req %b data_req %b mem_err %b, expected state %0d",
               name, dbg2, bus2.inst_req, bus2.data_req, bus2.mem_err, st);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t a;
    rst = 1'b1; bus.ir_op = 6'h03; bus.inst_ack = 1'b1; bus.data_ack = 1'b1;
    @(negedge clk);
    a = sample_main();
    checks++;
    if (OW'(a) !== OW'(0)) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", OW'(a));
    end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_addu();
    do_reset();
    push_inst(6'h00, 6'h21, 0, 0, 2);
    push_inst(6'h02, 6'h00, 0, 0, 2);
    run_trace("addu", 100);
  endtask

  task automatic test_lw_delay();
    do_reset();
    push_inst(6'h23, 6'h00, 1, 3, 2);
    push_inst(6'h2B, 6'h00, 0, 2, 2);
    run_trace("lw_sw_delay", 100);
  endtask

  task automatic test_branch();
    do_reset();
    push_inst(6'h04, 6'h00, 0, 0, 1);
    push_inst(6'h04, 6'h00, 0, 0, 0);
    push_inst(6'h05, 6'h00, 0, 0, 1);
    push_inst(6'h05, 6'h00, 0, 0, 0);
    push_inst(6'h00, 6'h08, 0, 0, 2);
    run_trace("branch", 100);
  endtask

  task automatic test_jal_illegal();
    do_reset();
    push_inst(6'h03, 6'h00, 0, 0, 2);
    push_inst(6'h3F, 6'h00, 0, 0, 2);
    push_inst(6'h00, 6'h3F, 0, 0, 2);
    push_inst(6'h02, 6'h00, 2, 0, 2);
    run_trace("jal_illegal", 100);
  endtask

  task automatic test_back_to_back();
    logic [5:0] op, fn;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 14))
        0: op = 6'h09; 1: op = 6'h0B; 2: op = 6'h0C; 3: op = 6'h0D; 4: op = 6'h0F;
        5: op = 6'h23; 6: op = 6'h2B; 7: op = 6'h04; 8: op = 6'h05; 9: op = 6'h02;
        10: op = 6'h03; 11: op = 6'($urandom); default: op = 6'h00;
      endcase
      case ($urandom_range(0, 8))
        0: fn = 6'h21; 1: fn = 6'h23; 2: fn = 6'h24; 3: fn = 6'h25; 4: fn = 6'h2A;
        5: fn = 6'h2B; 6: fn = 6'h00; 7: fn = 6'h08; default: fn = 6'($urandom);
      endcase
      push_inst(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 2);
    end
    run_trace("random", 2000);
  endtask

  task automatic test_mid_reset();
    obs_t a;
    do_reset();
    push_inst(6'h00, 6'h21, 0, 0, 2);
    run_trace("mid_reset_pre", 2);
    exp_q.delete(); stim_q.delete();
    rst = 1'b1; bus.ir_op = 6'h00; bus.ir_funct = 6'h21; bus.inst_ack = 1'b1; bus.data_ack = 1'b1;
    @(negedge clk);
    a = sample_main();
    checks++;
    if (OW'(a) !== OW'(0)) begin
      errors++; $display("FAIL mid_reset_outputs: got %h expected 0", OW'(a));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    push_inst(6'h02, 6'h00, 1, 0, 2);
    run_trace("after_mid_reset", 100);
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 4; i++) step_to(3'd0, "to_if_wait");
    step_to(3'd5, "to_halt");
    bus2.inst_ack = 1'b1; bus2.data_ack = 1'b1;
    step_to(3'd5, "to_halt_hold");
    step_to(3'd5, "to_halt_hold");
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dbg2 !== 3'd0 || bus2.mem_err !== 1'b0 || bus2.inst_req !== 1'b0) begin
      errors++; $display("FAIL to_reset: state %0d mem_err %b inst_req %b", dbg2, bus2.mem_err, bus2.inst_req);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus2.inst_ack = 1'b0; bus2.data_ack = 1'b0; bus2.ir_op = 6'h02;
    for (int i = 0; i < 3; i++) step_to(3'd0, "to_ack_wins_wait");
    bus2.inst_ack = 1'b1;
    step_to(3'd0, "to_ack_wins_last");
    bus2.inst_ack = 1'b0;
    step_to(3'd1, "to_ack_wins_id");
    bus2.ir_op = 6'h2B; bus2.inst_ack = 1'b1;
    step_to(3'd0, "to_sw_fetch");
    bus2.inst_ack = 1'b0;
    step_to(3'd1, "to_sw_id");
    step_to(3'd2, "to_sw_ex");
    for (int i = 0; i < 4; i++) step_to(3'd3, "to_mem_wait");
    step_to(3'd5, "to_mem_halt");
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_addu();
    test_lw_delay();
    test_branch();
    test_jal_illegal();
    test_back_to_back();
    test_mid_reset();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
